step_pulse_gen: RTL and testbench
=================================

Name: step_pulse_gen

Overview:
- Per-axis consumer of the signed 64-bit fixed-point speed words produced by the motion profile generator.
- Integrates speed into a fractional position accumulator on each step tick.
- Emits STEP/DIR pulses to the motor driver, chasing the accumulator's integer part with enforced dir-setup, pulse-high and pulse-low timing.
- Instantiated once per channel (8 total), between the speed outputs and the driver pins.

Parameters:
- FRAC_BITS, 32: fractional bits in speed/accumulator; legal range 1..32.
- STEP_WIDTH, 8: step high time in clk cycles, ≥1.
- STEP_LOW, 8: minimum step low time after each pulse in clk cycles, ≥1.
- DIR_SETUP, 16: cycles between a dir change and the following step rise, ≥1.
- MAX_LAG, 4: largest permitted |target − position| before lag error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allow accumulation and new pulses.
- step_tick  in  1  one-cycle strobe: integrate speed.
- speed  in  64  signed speed, steps/tick scaled by 2^FRAC_BITS.
- pos_load  in  1  load position.
- pos_in  in  32  signed position to load.
- err_clr  in  1  clear lag_err.
- step  out  1  step pulse to driver.
- dir  out  1  direction; 1 = positive.
- position  out  32  signed count of emitted steps.
- busy  out  1  state != S_IDLE.
- lag_err  out  1  sticky lag error.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: acc=0, position=0, step=0, dir=0, busy=0, lag_err=0, state=S_IDLE, cnt=0.
- Accumulator:
  - acc is 64-bit; acc <= acc + speed on step_tick & enable, wrapping mod 2^64.
  - target = acc[FRAC_BITS+31:FRAC_BITS].
  - diff = target − position, 32-bit wrapping subtract interpreted signed.
- pos_load (highest priority, any state, next cycle):
  - acc integer field = pos_in, fraction = 0, upper bits sign-extended; position = pos_in.
  - step=0, state=S_IDLE, dir unchanged.
  - A coincident step_tick is ignored.
- FSM, 4 states, single down-counter cnt:
  - S_IDLE: when enable & diff != 0, want = (diff > 0).
    - want != dir: dir <= want, cnt <= DIR_SETUP−1, go S_DIR_SETUP.
    - Otherwise: step <= 1, cnt <= STEP_WIDTH−1, go S_STEP_HI.
  - S_DIR_SETUP: decrement; at cnt==0, step <= 1, cnt <= STEP_WIDTH−1, go S_STEP_HI.
  - S_STEP_HI: decrement; at cnt==0, step <= 0, position <= position ± 1 per dir, cnt <= STEP_LOW−1, go S_STEP_LO.
  - S_STEP_LO: decrement; at cnt==0, go S_IDLE.
- Direction is re-evaluated only in S_IDLE. A sign reversal mid-pulse completes the current pulse first.
- enable low: acc frozen; an in-progress sequence completes; S_IDLE starts nothing.
- Step rate ceiling: one step per STEP_WIDTH+STEP_LOW+1 cycles (17 at defaults).
- lag_err:
  - Set on any cycle with |diff| > MAX_LAG.
  - err_clr clears it; set wins when both occur in the same cycle.
  - Stays set until cleared.
- Step rise is registered: one cycle after the FSM leaves S_IDLE / S_DIR_SETUP.

Optional Feature:
- Macro STEP_PULSE_GEN_ENDSTOP_EN.
- Defined: adds ports endstop_n (in, 1, active-low) and endstop_dir (in, 1, direction blocked by the endstop), plus endstop_hit (out, 1, sticky, cleared by err_clr).
  - In S_IDLE, if endstop_n==0 and want==endstop_dir, no pulse is started and endstop_hit is set.
  - acc keeps integrating, so lag_err may follow.
- Undefined: ports absent; stepping is unrestricted.

Test Plan:
- Reset, speed=0x0000_0000_4000_0000, step_tick every cycle for 16 cycles → dir rises, first step rise 16 cycles later, 4 pulses each 8 high / ≥8 low, position=4, lag_err=0.
- After test 1, speed=−0x0000_0001_0000_0000, a single tick → dir falls, step rises 16 cycles later, position=3.
- speed=0x0000_0001_0000_0000, tick every cycle → lag_err set by cycle ~6; err_clr while lag persists → stays 1; tick stopped, position catches up, then err_clr → 0.
- pos_load, pos_in=1000, during S_STEP_HI → step=0 next cycle, position=1000, no increment, busy=0.
- pos_load 0x7FFF_FFFF, then one tick with speed=1.0 → one positive pulse, position=0x8000_0000, no lag_err.
- With STEP_PULSE_GEN_ENDSTOP_EN: endstop_n=0, endstop_dir=1, positive demand → no pulses, endstop_hit=1; negative demand → pulses proceed.

Source files
------------

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: one axis of STEP/DIR pulse generation.
// Speed (signed, FRAC_BITS fraction) is integrated into a 64-bit accumulator on
// each step_tick. The FSM then emits pulses until the emitted step count
// ('position') matches the accumulator's integer part. Dir-setup, step-high and
// step-low times are enforced by a single down-counter.
// Optional build macro STEP_PULSE_GEN_ENDSTOP_EN adds an endstop that blocks
// pulses in one direction.
module step_pulse_gen #(
    parameter int FRAC_BITS  = 32,
    parameter int STEP_WIDTH = 8,
    parameter int STEP_LOW   = 8,
    parameter int DIR_SETUP  = 16,
    parameter int MAX_LAG    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        step_tick,
    input  logic [63:0] speed,
    input  logic        pos_load,
    input  logic [31:0] pos_in,
    input  logic        err_clr,
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    input  logic        endstop_n,
    input  logic        endstop_dir,
    output logic        endstop_hit,
`endif
    output logic        step,
    output logic        dir,
    output logic [31:0] position,
    output logic        busy,
    output logic        lag_err
);

    localparam int CMAX_A = (STEP_WIDTH > STEP_LOW) ? STEP_WIDTH : STEP_LOW;
    localparam int CMAX   = (DIR_SETUP > CMAX_A) ? DIR_SETUP : CMAX_A;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_STEP_HI,
        S_STEP_LO
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            step_d, dir_d;
    logic [31:0]     pos_d;
    logic [63:0]     acc;
    logic [63:0]     pos_sx;
    logic [63:0]     load_acc;
    logic [31:0]     target;
    logic signed [31:0] diff;
    logic            want;
    logic            lag_now;
    logic            blocked;

    assign target   = acc[FRAC_BITS+31 -: 32];
    assign diff     = target - position;
    assign want     = (diff > 0);
    assign lag_now  = (diff > MAX_LAG) || (diff < -MAX_LAG);
    // Loaded position lands in the integer field; the sign fills bits above it.
    assign pos_sx   = {{32{pos_in[31]}}, pos_in};
    assign load_acc = pos_sx << FRAC_BITS;
    assign busy     = (state != S_IDLE);

`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    assign blocked = !endstop_n && (want == endstop_dir);
`else
    assign blocked = 1'b0;
`endif

    // Accumulator: load wins over integration; wraps mod 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (pos_load)
            acc <= load_acc;
        else if (step_tick && enable)
            acc <= acc + speed;
    end

    // Sticky lag error; a fresh lag beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lag_err <= 1'b0;
        else if (lag_now)
            lag_err <= 1'b1;
        else if (err_clr)
            lag_err <= 1'b0;
    end

`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    // Sticky endstop flag, raised whenever the idle FSM refuses a blocked pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            endstop_hit <= 1'b0;
        else if (!pos_load && state == S_IDLE && enable && diff != 0 && blocked)
            endstop_hit <= 1'b1;
        else if (err_clr)
            endstop_hit <= 1'b0;
    end
`endif

    // FSM and pulse output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            position <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            step     <= step_d;
            dir      <= dir_d;
            position <= pos_d;
        end
    end

    // Next state: direction is chosen only in idle, so a running pulse always completes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        step_d  = step;
        dir_d   = dir;
        pos_d   = position;
        if (pos_load) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            step_d  = 1'b0;
            pos_d   = pos_in;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && diff != 0 && !blocked) begin
                        if (want != dir) begin
                            dir_d   = want;
                            cnt_d   = CW'(DIR_SETUP - 1);
                            state_d = S_DIR_SETUP;
                        end else begin
                            step_d  = 1'b1;
                            cnt_d   = CW'(STEP_WIDTH - 1);
                            state_d = S_STEP_HI;
                        end
                    end
                end
                S_DIR_SETUP: begin
                    if (cnt == '0) begin
                        step_d  = 1'b1;
                        cnt_d   = CW'(STEP_WIDTH - 1);
                        state_d = S_STEP_HI;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                S_STEP_HI: begin
                    if (cnt == '0) begin
                        step_d  = 1'b0;
                        pos_d   = dir ? position + 32'd1 : position - 32'd1;
                        cnt_d   = CW'(STEP_LOW - 1);
                        state_d = S_STEP_LO;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                S_STEP_LO: begin
                    if (cnt == '0)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: stimulus pushes expected pulses into a queue, a
// monitor pops one at every step fall and checks dir, position and high width,
// plus low time and dir-setup at every rise.
module tb_step_pulse_gen;

    localparam int STEP_WIDTH = 8;
    localparam int STEP_LOW   = 8;
    localparam int DIR_SETUP  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        step_tick = 1'b0;
    logic [63:0] speed = '0;
    logic        pos_load = 1'b0;
    logic [31:0] pos_in = '0;
    logic        err_clr = 1'b0;
    logic        step, dir, busy, lag_err;
    logic [31:0] position;
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
    logic        endstop_n = 1'b1;
    logic        endstop_dir = 1'b0;
    logic        endstop_hit;
`endif

    always #5 clk = ~clk;

    step_pulse_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .step_tick(step_tick),
        .speed(speed), .pos_load(pos_load), .pos_in(pos_in), .err_clr(err_clr),
`ifdef STEP_PULSE_GEN_ENDSTOP_EN
        .endstop_n(endstop_n), .endstop_dir(endstop_dir), .endstop_hit(endstop_hit),
`endif
        .step(step), .dir(dir), .position(position), .busy(busy), .lag_err(lag_err)
    );

    typedef struct {
        logic        d;
        logic [31:0] p;
        int          w;
    } pulse_t;

    pulse_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic [31:0] p, input int w);
        pulse_t e;
        e.d = d; e.p = p; e.w = w;
        exp_q.push_back(e);
    endtask

    // Monitor: pulse shape and scoreboard compare, sampled on falling edges.
    logic prev_step, prev_dir;
    int   hi_cnt, lo_cnt, dir_age;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_step = 1'b0; prev_dir = 1'b0;
            hi_cnt = 0; lo_cnt = 1000; dir_age = 1000;
        end else begin
            if (dir !== prev_dir) dir_age = 0;
            else if (dir_age < 1000) dir_age++;
            if (step && !prev_step) begin
                check("low_time_ok", 64'(lo_cnt >= STEP_LOW), 64'd1);
                check("dir_setup_ok", 64'(dir_age >= DIR_SETUP), 64'd1);
                hi_cnt = 1;
            end else if (step) begin
                hi_cnt++;
            end
            if (!step && prev_step) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: got pulse at position %0h expected none", position);
                end else begin
                    pulse_t e;
                    e = exp_q.pop_front();
                    check("pulse_dir", 64'(prev_dir), 64'(e.d));
                    check("pulse_pos", 64'(position), 64'(e.p));
                    check("pulse_width", 64'(hi_cnt), 64'(e.w));
                end
                lo_cnt = 1;
            end else if (!step && lo_cnt < 1000) begin
                lo_cnt++;
            end
            prev_step = step;
            prev_dir  = dir;
        end
    end

    task automatic ticks(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            step_tick = 1'b1; speed = s;
            @(negedge clk);
        end
        step_tick = 1'b0;
    endtask

    task automatic wait_pos(input string name, input logic [31:0] p, input int budget);
        int k = 0;
        while (position !== p && k < budget) begin
            @(negedge clk); k++;
        end
        check(name, 64'(position), 64'(p));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk); k++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_step", 64'(step), 64'd0);
        check("rst_dir", 64'(dir), 64'd0);
        check("rst_position", 64'(position), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_lag_err", 64'(lag_err), 64'd0);
        rst_n = 1'b1; enable = 1'b1;
        @(negedge clk);

        // 0.25 step/tick for 16 ticks: four positive pulses.
        for (int i = 1; i <= 4; i++) push(1'b1, 32'(i), STEP_WIDTH);
        ticks(64'h0000_0000_4000_0000, 16);
        wait_pos("t1_position", 32'd4, 300);
        wait_idle("t1_idle", 50);
        check("t1_lag_err", 64'(lag_err), 64'd0);
        check("t1_dir", 64'(dir), 64'd1);

        // One tick of -1.0: direction flips, one negative pulse.
        push(1'b0, 32'd3, STEP_WIDTH);
        ticks(64'hFFFF_FFFF_0000_0000, 1);
        wait_pos("t2_position", 32'd3, 100);
        wait_idle("t2_idle", 50);
        check("t2_dir", 64'(dir), 64'd0);

        // +1.0 every tick for 10 ticks: lag error, clear refused while lagging.
        for (int i = 4; i <= 13; i++) push(1'b1, 32'(i), STEP_WIDTH);
        ticks(64'h0000_0001_0000_0000, 10);
        check("t3_lag_set", 64'(lag_err), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_lag_clr_refused", 64'(lag_err), 64'd1);
        wait_pos("t3_position", 32'd13, 400);
        wait_idle("t3_idle", 50);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_lag_cleared", 64'(lag_err), 64'd0);

        // Abort a pulse with pos_load while step is high.
        push(1'b1, 32'd1000, 1);
        ticks(64'h0000_0001_0000_0000, 1);
        begin
            int k = 0;
            while (step !== 1'b1 && k < 50) begin
                @(negedge clk); k++;
            end
            check("t4_step_started", 64'(step), 64'd1);
        end
        pos_load = 1'b1; pos_in = 32'd1000;
        @(negedge clk);
        pos_load = 1'b0;
        check("t4_step_low", 64'(step), 64'd0);
        check("t4_position", 64'(position), 64'd1000);
        check("t4_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        check("t4_position_held", 64'(position), 64'd1000);

        // Signed wrap of the position counter.
        pos_load = 1'b1; pos_in = 32'h7FFF_FFFF;
        @(negedge clk);
        pos_load = 1'b0;
        check("t5_loaded", 64'(position), 64'h7FFF_FFFF);
        push(1'b1, 32'h8000_0000, STEP_WIDTH);
        ticks(64'h0000_0001_0000_0000, 1);
        wait_pos("t5_position", 32'h8000_0000, 100);
        wait_idle("t5_idle", 50);
        check("t5_lag_err", 64'(lag_err), 64'd0);

`ifdef STEP_PULSE_GEN_ENDSTOP_EN
        // Endstop blocks positive demand, negative demand still steps.
        endstop_n = 1'b0; endstop_dir = 1'b1;
        ticks(64'h0000_0001_0000_0000, 1);
        repeat (30) @(negedge clk);
        check("es_position_held", 64'(position), 64'h8000_0000);
        check("es_hit", 64'(endstop_hit), 64'd1);
        check("es_step_low", 64'(step), 64'd0);
        push(1'b0, 32'h7FFF_FFFF, STEP_WIDTH);
        ticks(64'hFFFF_FFFE_0000_0000, 1);
        wait_pos("es_neg_position", 32'h7FFF_FFFF, 100);
        wait_idle("es_idle", 50);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
